enc_arbiter: RTL and testbench

ENC_ARBITER -- requirements
Module: enc_arbiter

---
 rtl/enc_arbiter_if.sv | 54 +++++
 rtl/enc_arbiter.sv | 132 +++++++++++++
 tb/tb_enc_arbiter.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/enc_arbiter_if.sv
// Handshake bundle between two character requesters, the cipher core and
// the enc_arbiter that time-shares the core between them.
//
//   a_valid/a_ready, b_valid/b_ready : requester handshakes
//   sel                              : datapath mux select (0 = A, 1 = B)
//   core_start, core_done, core_char : cipher core launch / result
//   resp_char, resp_a, resp_b        : result returned to the owning requester
//   err_timeout                      : core failed to answer in time
//
// master: the arbiter side. slave: the requesters / core environment side.
interface enc_arbiter_if;
  logic       a_valid;
  logic       a_ready;
  logic       b_valid;
  logic       b_ready;
  logic       sel;
  logic       core_start;
  logic       core_done;
  logic [7:0] core_char;
  logic [7:0] resp_char;
  logic       resp_a;
  logic       resp_b;
  logic       err_timeout;

  modport master (
    input  a_valid,
    input  b_valid,
    input  core_done,
    input  core_char,
    output a_ready,
    output b_ready,
    output sel,
    output core_start,
    output resp_char,
    output resp_a,
    output resp_b,
    output err_timeout
  );

  modport slave (
    output a_valid,
    output b_valid,
    output core_done,
    output core_char,
    input  a_ready,
    input  b_ready,
    input  sel,
    input  core_start,
    input  resp_char,
    input  resp_a,
    input  resp_b,
    input  err_timeout
  );
endinterface

// File: rtl/enc_arbiter.sv
// Two-requester round-robin arbiter in front of a single cipher core.
// A granted request launches the core for one cycle, the arbiter then waits
// for core_done (bounded by TIMEOUT cycles) and returns the registered result
// to the requester that owned the operation.
//
// Ports:
//   clk  : system clock, all state changes on the rising edge
//   rst  : synchronous active-high reset
//   bus  : enc_arbiter_if.master (requester handshakes, core control,
//          response and timeout outputs)
//
// Parameter:
//   TIMEOUT : WAIT cycles allowed before the operation is abandoned (1..255)
module enc_arbiter #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          rst,
  enc_arbiter_if.master bus
);

  // Last WAIT count value at which a missing core_done is declared a timeout.
  localparam logic [7:0] Limit = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StGrant, StWait, StResp} state_e;

  state_e     state_q, state_d;
  logic       sel_q, sel_d;
  logic       ptr_q, ptr_d;       // preferred requester on contention (0 = A)
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] resp_char_q, resp_char_d;
  logic       err_q, err_d;

  logic       a_ready, b_ready, core_start, resp_a, resp_b;
  logic       sel_valid;

  assign sel_valid = sel_q ? bus.b_valid : bus.a_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      sel_q       <= 1'b0;
      ptr_q       <= 1'b0;
      cnt_q       <= 8'h00;
      resp_char_q <= 8'h00;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      resp_char_q <= resp_char_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    resp_char_d = resp_char_q;
    err_d       = 1'b0;
    a_ready     = 1'b0;
    b_ready     = 1'b0;
    core_start  = 1'b0;
    resp_a      = 1'b0;
    resp_b      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.a_valid && bus.b_valid) begin
          sel_d   = ptr_q;
          state_d = StGrant;
        end else if (bus.a_valid) begin
          sel_d   = 1'b0;
          state_d = StGrant;
        end else if (bus.b_valid) begin
          sel_d   = 1'b1;
          state_d = StGrant;
        end
      end

      StGrant: begin
        // A requester that dropped valid before being served loses its slot
        // without consuming its round-robin turn.
        if (sel_valid) begin
          core_start = 1'b1;
          a_ready    = ~sel_q;
          b_ready    = sel_q;
          cnt_d      = 8'h00;
          state_d    = StWait;
        end else begin
          state_d = StIdle;
        end
      end

      StWait: begin
        // core_done takes priority over the timeout on the limit cycle.
        if (bus.core_done) begin
          resp_char_d = bus.core_char;
          state_d     = StResp;
        end else if (cnt_q == Limit) begin
          err_d   = 1'b1;
          ptr_d   = ~ptr_q;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      StResp: begin
        resp_a  = ~sel_q;
        resp_b  = sel_q;
        ptr_d   = ~ptr_q;
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  assign bus.a_ready     = a_ready;
  assign bus.b_ready     = b_ready;
  assign bus.sel         = sel_q;
  assign bus.core_start  = core_start;
  assign bus.resp_char   = resp_char_q;
  assign bus.resp_a      = resp_a;
  assign bus.resp_b      = resp_b;
  assign bus.err_timeout = err_q;

endmodule

// File: tb/tb_enc_arbiter.sv
// Directed bench for enc_arbiter (TIMEOUT = 4). Stimulus pushes expected
// grants and responses into queues; monitors pop and compare whenever the
// DUT presents core_start or a resp/err pulse.
module tb_enc_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;

  enc_arbiter_if bus ();

  enc_arbiter #(
    .TIMEOUT(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       ra;
    logic       rb;
    logic       err;
    logic [7:0] ch;
  } resp_t;

  logic  grant_q[$];
  resp_t resp_q[$];

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic fail_now(input string name, input logic [31:0] act);
    total_cnt++;
    $display("FAIL %s: got %0h, expected no event (t=%0t)", name, act, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Grant and response monitors
  logic  mon_sel;
  resp_t mon_r;
  always @(negedge clk) begin
    if (bus.core_start) begin
      if (grant_q.size() == 0) begin
        fail_now("unexpected_start", {31'd0, bus.sel});
      end else begin
        mon_sel = grant_q.pop_front();
        check("grant_sel", {31'd0, bus.sel}, {31'd0, mon_sel});
        check("grant_ready", {30'd0, bus.a_ready, bus.b_ready}, {30'd0, ~mon_sel, mon_sel});
      end
    end
    if (bus.resp_a || bus.resp_b || bus.err_timeout) begin
      if (resp_q.size() == 0) begin
        fail_now("unexpected_resp",
                 {21'd0, bus.resp_a, bus.resp_b, bus.err_timeout, bus.resp_char});
      end else begin
        mon_r = resp_q.pop_front();
        check("resp_event", {21'd0, bus.resp_a, bus.resp_b, bus.err_timeout, bus.resp_char},
              {21'd0, mon_r});
      end
    end
  end

  function automatic logic [5:0] ctrl_outs();
    return {bus.a_ready, bus.b_ready, bus.core_start, bus.resp_a, bus.resp_b, bus.err_timeout};
  endfunction

  task automatic do_reset();
    bus.a_valid   = 1'b0;
    bus.b_valid   = 1'b0;
    bus.core_done = 1'b0;
    bus.core_char = 8'h00;
    rst = 1'b1;
    step();
    step();
    check("rst_ctrl", {26'd0, ctrl_outs()}, 32'd0);
    check("rst_sel", {31'd0, bus.sel}, 32'd0);
    check("rst_resp_char", {24'd0, bus.resp_char}, 32'd0);
    rst = 1'b0;
  endtask

  // One full operation starting from an IDLE cycle. waits = WAIT cycles before
  // core_done; keep = leave the valids asserted after the grant.
  task automatic run_op(input bit a, input bit b, input bit exp_sel, input int waits,
                        input logic [7:0] ch, input bit keep);
    int n;
    n = 0;
    grant_q.push_back(exp_sel);
    resp_q.push_back({~exp_sel, exp_sel, 1'b0, ch});
    bus.a_valid = a;
    bus.b_valid = b;
    do begin
      step();
      n++;
    end while (!bus.core_start && n < 8);
    check("grant_latency", n, 1);
    if (!bus.core_start) return;
    step();
    if (!keep) begin
      bus.a_valid = 1'b0;
      bus.b_valid = 1'b0;
    end
    repeat (waits) step();
    bus.core_done = 1'b1;
    bus.core_char = ch;
    step();
    bus.core_done = 1'b0;
    check("resp_pulse", {30'd0, bus.resp_a, bus.resp_b}, {30'd0, ~exp_sel, exp_sel});
    check("resp_char", {24'd0, bus.resp_char}, {24'd0, ch});
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // A only, core answers two cycles after start
    run_op(1'b1, 1'b0, 1'b0, 1, 8'h5A, 1'b0);
    check("resp_char_hold", {24'd0, bus.resp_char}, 32'h5A);
    check("idle_quiet", {26'd0, ctrl_outs()}, 32'd0);

    // Both valid continuously: A,B,A,B
    do_reset();
    run_op(1'b1, 1'b1, 1'b0, 0, 8'h11, 1'b1);
    run_op(1'b1, 1'b1, 1'b1, 1, 8'h22, 1'b1);
    run_op(1'b1, 1'b1, 1'b0, 2, 8'h33, 1'b1);
    run_op(1'b1, 1'b1, 1'b1, 1, 8'h44, 1'b0);
    step();

    // Timeout: core never answers
    do_reset();
    grant_q.push_back(1'b0);
    resp_q.push_back({1'b0, 1'b0, 1'b1, 8'h00});
    bus.a_valid = 1'b1;
    step();
    check("to_start", {31'd0, bus.core_start}, 32'd1);
    step();
    bus.a_valid = 1'b0;
    repeat (3) step();
    check("to_err_early", {31'd0, bus.err_timeout}, 32'd0);
    step();
    check("to_err_pulse", {31'd0, bus.err_timeout}, 32'd1);
    check("to_no_resp", {30'd0, bus.resp_a, bus.resp_b}, 32'd0);
    step();
    check("to_err_single", {31'd0, bus.err_timeout}, 32'd0);
    run_op(1'b1, 1'b1, 1'b1, 0, 8'h77, 1'b0);

    // core_done on the timeout limit cycle: done wins
    run_op(1'b1, 1'b0, 1'b0, 3, 8'h99, 1'b0);
    step();
    check("limit_no_err", {31'd0, bus.err_timeout}, 32'd0);

    // B withdraws in GRANT (pointer currently prefers B)
    bus.b_valid = 1'b1;
    step();
    bus.b_valid = 1'b0;
    #1;
    check("wd_no_start", {30'd0, bus.core_start, bus.b_ready}, 32'd0);
    check("wd_sel", {31'd0, bus.sel}, 32'd1);
    step();
    check("wd_idle_quiet", {26'd0, ctrl_outs()}, 32'd0);
    run_op(1'b1, 1'b1, 1'b1, 0, 8'hB1, 1'b0);

    // Reset during WAIT, then a stale core_done
    run_op(1'b1, 1'b0, 1'b0, 0, 8'hA7, 1'b0);
    grant_q.push_back(1'b1);
    bus.b_valid = 1'b1;
    step();
    check("rw_start", {31'd0, bus.core_start}, 32'd1);
    step();
    bus.b_valid = 1'b0;
    rst = 1'b1;
    step();
    check("rw_ctrl", {26'd0, ctrl_outs()}, 32'd0);
    check("rw_sel", {31'd0, bus.sel}, 32'd0);
    check("rw_resp_char", {24'd0, bus.resp_char}, 32'd0);
    rst = 1'b0;
    bus.core_done = 1'b1;
    bus.core_char = 8'hEE;
    step();
    bus.core_done = 1'b0;
    check("rw_stale_done", {26'd0, ctrl_outs()}, 32'd0);
    step();
    check("rw_stale_done2", {26'd0, ctrl_outs()}, 32'd0);
    check("rw_char_kept", {24'd0, bus.resp_char}, 32'd0);
    run_op(1'b1, 1'b1, 1'b0, 1, 8'h3C, 1'b0);

    repeat (3) step();
    check("grant_q_empty", grant_q.size(), 0);
    check("resp_q_empty", resp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
